// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : shares one fixed-latency data memory between two requesters
//   with round-robin grants, one outstanding transaction and a watchdog.
//   Optional macro DMEM_ARB_CONST_TIME_EN: TDM grants and fixed response time.
// Revision: 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 15,
  parameter int CT_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_fcn,
  input  logic [2:0]        req0_typ,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_data,
  output logic              resp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_fcn,
  input  logic [2:0]        req1_typ,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_data,
  output logic              resp1_err,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic              mem_req_fcn,
  output logic [2:0]        mem_req_typ,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy,
  output logic              owner
);

`ifdef DMEM_ARB_CONST_TIME_EN
  localparam bit c_ct_mode = 1'b1;
`else
  localparam bit c_ct_mode = 1'b0;
`endif
  // Timer value in the last WAIT cycle: RESP lands at accept + CT_CYCLES in
  // constant-time mode, or after TIMEOUT silent WAIT cycles otherwise.
  localparam int         c_wait_last_int = c_ct_mode ? (CT_CYCLES - 3) : (TIMEOUT - 1);
  localparam logic [7:0] c_wait_last     = 8'(c_wait_last_int);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t            state_q;
  logic              owner_q;
  logic              busy_q;
  logic [7:0]        timer_q;
  logic              mem_req_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              fcn_q;
  logic [2:0]        typ_q;
  logic              resp0_valid_q, resp1_valid_q;
  logic [DATA_W-1:0] resp0_data_q, resp1_data_q;
  logic              resp0_err_q, resp1_err_q;
`ifdef DMEM_ARB_CONST_TIME_EN
  logic              slot_q;
  logic              got_q;
  logic [DATA_W-1:0] buf_q;
`else
  logic              last_grant_q;
`endif

  logic              grant_vld, grant_id;
  logic              wait_done, done_err, have_rsp;
  logic [DATA_W-1:0] done_data, rsp_data;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
`ifdef DMEM_ARB_CONST_TIME_EN
    if (slot_q) begin
      grant_vld = req1_valid;
      grant_id  = 1'b1;
    end else begin
      grant_vld = req0_valid;
    end
`else
    if (req0_valid && req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = ~last_grant_q;
    end else if (req0_valid) begin
      grant_vld = 1'b1;
    end else if (req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b1;
    end
`endif
    if (state_q != ST_IDLE || !reset_n) grant_vld = 1'b0;
  end

  assign req0_ready = grant_vld & ~grant_id;
  assign req1_ready = grant_vld &  grant_id;

  always_comb begin
`ifdef DMEM_ARB_CONST_TIME_EN
    have_rsp  = got_q | mem_resp_valid;
    rsp_data  = got_q ? buf_q : mem_resp_data;
    wait_done = (timer_q == c_wait_last);
`else
    have_rsp  = mem_resp_valid;
    rsp_data  = mem_resp_data;
    wait_done = mem_resp_valid || (timer_q == c_wait_last);
`endif
    done_err  = ~have_rsp;
    done_data = (have_rsp && !fcn_q) ? rsp_data : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      owner_q         <= 1'b0;
      busy_q          <= 1'b0;
      timer_q         <= '0;
      mem_req_valid_q <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      fcn_q           <= 1'b0;
      typ_q           <= '0;
      resp0_valid_q   <= 1'b0;
      resp0_data_q    <= '0;
      resp0_err_q     <= 1'b0;
      resp1_valid_q   <= 1'b0;
      resp1_data_q    <= '0;
      resp1_err_q     <= 1'b0;
`ifdef DMEM_ARB_CONST_TIME_EN
      slot_q          <= 1'b0;
      got_q           <= 1'b0;
      buf_q           <= '0;
`else
      last_grant_q    <= 1'b1;
`endif
    end else begin
      mem_req_valid_q <= 1'b0;
      resp0_valid_q   <= 1'b0;
      resp1_valid_q   <= 1'b0;
`ifdef DMEM_ARB_CONST_TIME_EN
      slot_q          <= ~slot_q;
`endif
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            addr_q          <= grant_id ? req1_addr : req0_addr;
            wdata_q         <= grant_id ? req1_data : req0_data;
            fcn_q           <= grant_id ? req1_fcn  : req0_fcn;
            typ_q           <= grant_id ? req1_typ  : req0_typ;
            owner_q         <= grant_id;
`ifndef DMEM_ARB_CONST_TIME_EN
            last_grant_q    <= grant_id;
`endif
            mem_req_valid_q <= 1'b1;
            busy_q          <= 1'b1;
            state_q         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer_q <= '0;
`ifdef DMEM_ARB_CONST_TIME_EN
          got_q   <= 1'b0;
`endif
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_done) begin
            state_q <= ST_RESP;
            if (owner_q) begin
              resp1_valid_q <= 1'b1;
              resp1_data_q  <= done_data;
              resp1_err_q   <= done_err;
            end else begin
              resp0_valid_q <= 1'b1;
              resp0_data_q  <= done_data;
              resp0_err_q   <= done_err;
            end
          end else begin
            timer_q <= timer_q + 8'd1;
          end
`ifdef DMEM_ARB_CONST_TIME_EN
          // Early responses are parked until the fixed deadline.
          if (mem_resp_valid && !got_q) begin
            got_q <= 1'b1;
            buf_q <= mem_resp_data;
          end
`endif
        end
        default: begin
          resp0_data_q <= '0;
          resp0_err_q  <= 1'b0;
          resp1_data_q <= '0;
          resp1_err_q  <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = wdata_q;
  assign mem_req_fcn   = fcn_q;
  assign mem_req_typ   = typ_q;
  assign resp0_valid   = resp0_valid_q;
  assign resp0_data    = resp0_data_q;
  assign resp0_err     = resp0_err_q;
  assign resp1_valid   = resp1_valid_q;
  assign resp1_data    = resp1_data_q;
  assign resp1_err     = resp1_err_q;
  assign busy          = busy_q;
  assign owner         = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : directed scenarios plus randomized traffic checked against
//   a transaction-level model of grants, latency and response contents.
// Revision: 1.0
// ============================================================================
module tb_dmem_arbiter;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int TIMEOUT   = 15;
  localparam int CT_CYCLES = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic              req0_ready, req1_ready;
  logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
  logic [DATA_W-1:0] req0_data = '0, req1_data = '0;
  logic              req0_fcn = 1'b0, req1_fcn = 1'b0;
  logic [2:0]        req0_typ = '0, req1_typ = '0;
  logic              resp0_valid, resp1_valid, resp0_err, resp1_err;
  logic [DATA_W-1:0] resp0_data, resp1_data;
  logic              mem_req_valid, mem_req_fcn;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic [2:0]        mem_req_typ;
  logic              mem_resp_valid = 1'b0;
  logic [DATA_W-1:0] mem_resp_data = '0;
  logic              busy, owner;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CT_CYCLES(CT_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_fcn(req0_fcn), .req0_typ(req0_typ),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_fcn(req1_fcn), .req1_typ(req1_typ),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_err(resp1_err),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_fcn(mem_req_fcn), .mem_req_typ(mem_req_typ),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int rel_cyc = 0;
  int mem_lat = 4;

  always @(posedge clk) cyc++;

  // Memory: answers each issue pulse mem_lat cycles later; stores return junk.
  typedef struct { int due; logic [31:0] data; } mrsp_t;
  mrsp_t mq[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'hDEADBEEF;
    return (a * 32'h0100_0193) ^ 32'hC0FF_EE00;
  endfunction

  always @(posedge clk) begin
    #1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = mq[0].data;
      void'(mq.pop_front());
    end
    if (mem_req_valid)
      mq.push_back(mrsp_t'{cyc + mem_lat, mem_word(mem_req_addr) ^ (mem_req_fcn ? 32'h5555_AAAA : 32'h0)});
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    mq.delete();
    @(posedge clk); #1;
    reset_n = 1'b1; rel_cyc = cyc;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b required 00", req0_ready, req1_ready);
    end
    checks++;
    if ({mem_req_valid, resp0_valid, resp1_valid, resp0_err, resp1_err, busy, owner, mem_req_fcn} !== 8'h00) begin
      errors++; $display("FAIL reset_flags: got %b required 00000000",
        {mem_req_valid, resp0_valid, resp1_valid, resp0_err, resp1_err, busy, owner, mem_req_fcn});
    end
    checks++;
    if (mem_req_addr !== '0 || mem_req_data !== '0 || resp0_data !== '0 || resp1_data !== '0 || mem_req_typ !== '0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h r0=%h r1=%h required all 0",
        mem_req_addr, mem_req_data, resp0_data, resp1_data);
    end
    mq.delete();
    @(posedge clk); #1;
    reset_n = 1'b1; rel_cyc = cyc;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_first_grant: got %b%b required 10", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single_load();
    do_reset(); mem_lat = 4;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_addr = 32'h4; req0_fcn = 1'b0; req0_typ = 3'b010; req0_data = $urandom;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL load_ready: got %b%b required 10", req0_ready, req1_ready);
    end
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1; req0_valid = 1'b0; #1;
      checks++;
      if (mem_req_valid !== (k == 1)) begin
        errors++; $display("FAIL load_issue k=%0d: got %b required %b", k, mem_req_valid, k == 1);
      end
      if (k == 1) begin
        checks++;
        if (mem_req_addr !== 32'h4 || mem_req_fcn !== 1'b0 || mem_req_typ !== 3'b010) begin
          errors++; $display("FAIL load_fields: addr=%h fcn=%b typ=%b required 4/0/010", mem_req_addr, mem_req_fcn, mem_req_typ);
        end
      end
      checks++;
      if (resp0_valid !== (k == 6) || resp1_valid !== 1'b0 || busy !== (k <= 6)) begin
        errors++; $display("FAIL load_resp k=%0d: v0=%b v1=%b busy=%b required %b 0 %b", k, resp0_valid, resp1_valid, busy, k == 6, k <= 6);
      end
      if (k == 6) begin
        checks++;
        if (resp0_data !== 32'hDEADBEEF || resp0_err !== 1'b0) begin
          errors++; $display("FAIL load_data: got %h err %b required deadbeef err 0", resp0_data, resp0_err);
        end
      end
    end
  endtask

  task automatic test_store();
    do_reset(); mem_lat = 4;
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_addr = 32'h3C; req1_data = 32'h12345678; req1_fcn = 1'b1; req1_typ = 3'b010;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL store_ready: got %b%b required 01", req0_ready, req1_ready);
    end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1; req1_valid = 1'b0; #1;
      if (k == 1) begin
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3C || mem_req_data !== 32'h12345678 || mem_req_fcn !== 1'b1) begin
          errors++; $display("FAIL store_issue: v=%b addr=%h data=%h fcn=%b required 1/3c/12345678/1",
            mem_req_valid, mem_req_addr, mem_req_data, mem_req_fcn);
        end
      end
      checks++;
      if (resp1_valid !== (k == 6) || resp0_valid !== 1'b0 || owner !== 1'b1) begin
        errors++; $display("FAIL store_resp k=%0d: v1=%b v0=%b owner=%b required %b 0 1", k, resp1_valid, resp0_valid, owner, k == 6);
      end
      if (k == 6) begin
        checks++;
        if (resp1_data !== 32'h0 || resp1_err !== 1'b0) begin
          errors++; $display("FAIL store_data: got %h err %b required 0 err 0", resp1_data, resp1_err);
        end
      end
    end
  endtask

  task automatic test_contention();
    int   n;
    int   acc [4];
    logic g   [4];
    logic eg;
    n = 0;
    do_reset(); mem_lat = 4;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_addr = 32'h100; req0_fcn = 1'b0;
      req1_valid = 1'b1; req1_addr = 32'h200; req1_fcn = 1'b0;
      #1;
      checks++;
      if (req0_ready && req1_ready) begin
        errors++; $display("FAIL contention_both_ready: got 11 required at most one");
      end
      if (req0_ready || req1_ready) begin
        acc[n] = cyc; g[n] = req1_ready; n++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL contention_count: got %0d grants required 4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        eg = (i % 2) == 1;
        checks++;
        if (g[i] !== eg) begin
          errors++; $display("FAIL contention_order i=%0d: got %b required %b", i, g[i], eg);
        end
        if (i > 0) begin
          checks++;
          if (acc[i] - acc[i-1] != 7) begin
            errors++; $display("FAIL contention_gap i=%0d: got %0d required 7", i, acc[i] - acc[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_timeout();
    do_reset(); mem_lat = 20;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_addr = 32'h80; req0_fcn = 1'b0; #1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1; req0_valid = 1'b0; #1;
      checks++;
      if (resp0_valid !== (k == 17) || resp1_valid !== 1'b0 || busy !== (k <= 17)) begin
        errors++; $display("FAIL timeout_resp k=%0d: v0=%b v1=%b busy=%b required %b 0 %b", k, resp0_valid, resp1_valid, busy, k == 17, k <= 17);
      end
      if (k == 17) begin
        checks++;
        if (resp0_err !== 1'b1 || resp0_data !== 32'h0) begin
          errors++; $display("FAIL timeout_err: err=%b data=%h required 1 0", resp0_err, resp0_data);
        end
      end
    end
    mem_lat = 4;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_addr = 32'h4; #1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1; req0_valid = 1'b0; #1;
      checks++;
      if (resp0_valid !== (k == 6)) begin
        errors++; $display("FAIL timeout_next k=%0d: v0=%b required %b", k, resp0_valid, k == 6);
      end
      if (k == 6) begin
        checks++;
        if (resp0_data !== 32'hDEADBEEF || resp0_err !== 1'b0) begin
          errors++; $display("FAIL timeout_next_data: got %h err %b required deadbeef 0", resp0_data, resp0_err);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset(); mem_lat = 4;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_addr = 32'h40; req0_fcn = 1'b0;
    @(posedge clk); #1; req0_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0; #1;
    checks++;
    if ({busy, mem_req_valid, resp0_valid, resp1_valid, owner} !== 5'b0 || mem_req_addr !== '0) begin
      errors++; $display("FAIL midreset_outputs: flags=%b addr=%h required 0", {busy, mem_req_valid, resp0_valid, resp1_valid, owner}, mem_req_addr);
    end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1; rel_cyc = cyc;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL midreset_stale k=%0d: v0=%b v1=%b busy=%b required 0", k, resp0_valid, resp1_valid, busy);
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_grant: got %b%b required 10", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_random(input int ncyc);
    logic        m_last, m_own, e_fcn, e_err, ev, eid, drop0, drop1;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [2:0]  e_typ;
    int          idle_at, issue_at, resp_at, lat;
    m_last = 1'b1; m_own = 1'b0; drop0 = 1'b0; drop1 = 1'b0;
    e_fcn = 1'b0; e_err = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0; e_typ = '0;
    issue_at = -1; resp_at = -1;
    do_reset();
    idle_at = cyc;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      if (drop0) begin req0_valid = 1'b0; drop0 = 1'b0; end
      else if (!req0_valid) begin
        if ($urandom_range(0, 2) == 0) begin
          req0_valid = 1'b1; req0_addr = $urandom; req0_data = $urandom;
          req0_fcn = 1'($urandom_range(0, 1)); req0_typ = 3'($urandom_range(0, 7));
        end
      end else if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
      if (drop1) begin req1_valid = 1'b0; drop1 = 1'b0; end
      else if (!req1_valid) begin
        if ($urandom_range(0, 2) == 0) begin
          req1_valid = 1'b1; req1_addr = $urandom; req1_data = $urandom;
          req1_fcn = 1'($urandom_range(0, 1)); req1_typ = 3'($urandom_range(0, 7));
        end
      end else if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
      #1;
      ev  = (cyc >= idle_at) && (req0_valid || req1_valid);
      eid = (req0_valid && req1_valid) ? !m_last : !req0_valid;
      checks++;
      if (req0_ready !== (ev && !eid) || req1_ready !== (ev && eid)) begin
        errors++; $display("FAIL rand_ready cyc=%0d: got %b%b required %b%b", cyc, req0_ready, req1_ready, ev && !eid, ev && eid);
      end
      checks++;
      if (mem_req_valid !== (cyc == issue_at) || busy !== (cyc < idle_at) || owner !== m_own) begin
        errors++; $display("FAIL rand_state cyc=%0d: issue=%b busy=%b owner=%b required %b %b %b",
          cyc, mem_req_valid, busy, owner, cyc == issue_at, cyc < idle_at, m_own);
      end
      if (cyc == issue_at) begin
        checks++;
        if (mem_req_addr !== e_addr || mem_req_data !== e_wdata || mem_req_fcn !== e_fcn || mem_req_typ !== e_typ) begin
          errors++; $display("FAIL rand_fields cyc=%0d: %h %h %b %b required %h %h %b %b",
            cyc, mem_req_addr, mem_req_data, mem_req_fcn, mem_req_typ, e_addr, e_wdata, e_fcn, e_typ);
        end
      end
      checks++;
      if (resp0_valid !== (cyc == resp_at && !m_own) || resp1_valid !== (cyc == resp_at && m_own)) begin
        errors++; $display("FAIL rand_resp_valid cyc=%0d: got %b%b required %b%b",
          cyc, resp0_valid, resp1_valid, cyc == resp_at && !m_own, cyc == resp_at && m_own);
      end
      if (cyc == resp_at) begin
        checks++;
        if ((m_own ? resp1_data : resp0_data) !== e_rdata || (m_own ? resp1_err : resp0_err) !== e_err) begin
          errors++; $display("FAIL rand_resp_data cyc=%0d: got %h err %b required %h err %b",
            cyc, m_own ? resp1_data : resp0_data, m_own ? resp1_err : resp0_err, e_rdata, e_err);
        end
      end
      if (ev) begin
        m_own = eid; m_last = eid;
        e_addr  = eid ? req1_addr : req0_addr;
        e_wdata = eid ? req1_data : req0_data;
        e_fcn   = eid ? req1_fcn  : req0_fcn;
        e_typ   = eid ? req1_typ  : req0_typ;
        lat     = $urandom_range(1, 18);
        mem_lat = lat;
        e_err   = lat > TIMEOUT;
        e_rdata = (e_err || e_fcn) ? 32'h0 : mem_word(e_addr);
        issue_at = cyc + 1;
        resp_at  = cyc + (e_err ? TIMEOUT : lat) + 2;
        idle_at  = resp_at + 1;
        if (eid) drop1 = 1'b1; else drop0 = 1'b1;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

`ifdef DMEM_ARB_CONST_TIME_EN
  task automatic test_const_time();
    int t0;
    for (int p = 0; p < 2; p++) begin
      do_reset(); mem_lat = (p == 0) ? 2 : 4;
      t0 = -1;
      for (int k = 0; k < 6 && t0 < 0; k++) begin
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_addr = 32'h4; req1_fcn = 1'b0; #1;
        checks++;
        if (req1_ready && ((cyc - rel_cyc) % 2 == 0)) begin
          errors++; $display("FAIL ct_slot: req1 accepted on even slot %0d", cyc - rel_cyc);
        end
        if (req1_ready) t0 = cyc;
      end
      req1_valid = 1'b0;
      checks++;
      if (t0 < 0) begin
        errors++; $display("FAIL ct_accept: got no acceptance required one within 6 cycles");
      end
      for (int k = 1; k <= 10 && t0 >= 0; k++) begin
        @(posedge clk); #2;
        checks++;
        if (resp1_valid !== (k == CT_CYCLES)) begin
          errors++; $display("FAIL ct_resp lat=%0d k=%0d: got %b required %b", mem_lat, k, resp1_valid, k == CT_CYCLES);
        end
        if (k == CT_CYCLES) begin
          checks++;
          if (resp1_data !== 32'hDEADBEEF || resp1_err !== 1'b0) begin
            errors++; $display("FAIL ct_data: got %h err %b required deadbeef 0", resp1_data, resp1_err);
          end
        end
      end
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef DMEM_ARB_CONST_TIME_EN
    test_const_time();
`else
    test_single_load();
    test_store();
    test_contention();
    test_timeout();
    test_reset_mid_wait();
    test_random(1500);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single multi-cycle data memory (fixed-latency, cycle-counter based dmem) between two requesters, e.g. the core's load/store port and the load-buffer table fill path, or the two model copies in a shared-memory verification harness.
- Round-robin arbitration, one outstanding transaction, registered request issue, response routed back to the owner, watchdog timeout.
- Optional constant-time mode removes contention- and latency-dependent timing for the security flow.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 15, WAIT cycles without mem_resp_valid before an error response; 1..255.
- CT_CYCLES, 8, fixed accept-to-response distance in constant-time mode; must be ≥ memory latency + 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 request.
- req0_ready  out  1  requester 0 accept, combinational.
- req0_addr  in  ADDR_W  address.
- req0_data  in  DATA_W  store data.
- req0_fcn  in  1  1 = store, 0 = load.
- req0_typ  in  3  access size (funct3 encoding), passed through.
- resp0_valid  out  1  one-cycle response pulse.
- resp0_data  out  DATA_W  load data; 0 for stores and errors.
- resp0_err  out  1  timeout or late response, qualified by resp0_valid.
- req1_* / resp1_*  same set and widths for requester 1.
- mem_req_valid  out  1  one-cycle issue pulse to dmem.
- mem_req_addr  out  ADDR_W  latched address.
- mem_req_data  out  DATA_W  latched data.
- mem_req_fcn  out  1  latched fcn.
- mem_req_typ  out  3  latched typ.
- mem_resp_valid  in  1  dmem response.
- mem_resp_data  in  DATA_W  dmem response data.
- busy  out  1  state != IDLE.
- owner  out  1  id of the current or last granted requester.

Behaviour:
- Reset (async assert, sync deassert by design): state = IDLE, last_grant = 1 (requester 0 wins first), owner = 0, timers = 0. All outputs 0; req*_ready = 0 during reset.
- Outputs are registered except req*_ready.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = sole valid requester; if both valid, winner = !last_grant.
  - reqW_ready = 1 for the winner only, never both.
  - On handshake: latch fields, owner ← W, last_grant ← W, go to ISSUE.
- ISSUE: mem_req_valid = 1 for exactly one cycle with the latched fields; clear the timer; go to WAIT.
- WAIT:
  - On mem_resp_valid: latch data (stores latch 0) and go to RESP.
  - Otherwise timer++. When timer == TIMEOUT: set err, data = 0, go to RESP.
- RESP: respO_valid = 1 for one cycle, with data and err; go to IDLE.
- Latency, with the request accepted in cycle T and memory latency L: mem_req_valid at T+1, resp at T+L+2, next acceptance possible at T+L+3.
- Responses are never held; requesters have no backpressure.
- mem_resp_valid outside WAIT is ignored and does not corrupt state; a response arriving after a timeout is dropped.
- Requests that are valid while busy wait; ready stays 0.
- A requester may deassert valid before it is accepted without effect.
- An async reset mid-transaction aborts it: no response is emitted, and any in-flight dmem response is ignored after reset.

Optional Feature:
- Macro: DMEM_ARB_CONST_TIME_EN.
- When defined:
  - Arbitration is strict TDM: a free-running 1-bit slot counter toggles every cycle from reset; requester k may be accepted only in IDLE cycles where slot == k.
  - Response is delivered exactly CT_CYCLES after acceptance regardless of actual memory latency. WAIT holds until the counter expires; the actual data is buffered.
  - A memory response not received by the deadline yields err = 1, data = 0.
  - TIMEOUT is unused.
- When undefined: round-robin and variable latency as above; the slot counter is absent.

Test Plan (L = 4, defaults):
- Single load: req0 addr 0x4, mem returns 0xDEADBEEF → req0_ready at T; mem_req_valid at T+1 with addr 0x4, fcn 0; resp0_valid at T+6 with data 0xDEADBEEF, err 0; resp1_valid stays 0.
- Contention: req0 and req1 valid continuously after reset → grants 0,1,0,1; accepts 7 cycles apart; never both ready in one cycle.
- Store: req1 addr 0x3C, data 0x12345678, fcn 1 → mem_req_data 0x12345678, fcn 1; resp1_valid with data 0, err 0.
- Timeout: memory never responds → resp0_valid with err 1 exactly 15 WAIT cycles after ISSUE; a late mem_resp_valid is ignored; the next request completes normally.
- Reset mid-WAIT: drop reset_n two cycles after ISSUE → all outputs 0 immediately; after release, no stale response is emitted and requester 0 wins the first grant.
- DMEM_ARB_CONST_TIME_EN, memory latency 2 vs 4: resp at exactly T+8 in both cases; requester 1 is accepted only on odd slots.
